div_result_checker: RTL and testbench

Self-checking consumer stage that sits directly downstream of the `divider` in the divide test harness. It captures each operand pair at the moment a divide is launched and waits for the divider's result. It then verifies that quotient × divisor + remainder equals the dividend and that remainder is less than the divisor. Verdicts, held results and saturating pass/fail/timeout counters are exported to the manta debug core for UART readback.

---
 rtl/div_result_checker.sv | 141 ++++++++++++++
 tb/tb_div_result_checker.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_result_checker.sv
// Divider result checker: captures operands at launch, verifies q*d+r == dividend and r < d.
// Verdict registered 3 cycles after result_valid_in; a missing result completes as a timeout.
module div_result_checker #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  input  logic [WIDTH-1:0] quotient_in,
  input  logic [WIDTH-1:0] remainder_in,
  input  logic             result_valid_in,
  input  logic             error_in,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             pass_out,
  output logic [15:0]      pass_count_out,
  output logic [15:0]      fail_count_out,
  output logic [15:0]      timeout_count_out
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MUL, S_CMP} state_t;

  localparam int            CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t             state_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [WIDTH-1:0]   dividend_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   rem_q;
  logic               err_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]      wait_q;
  logic [WIDTH-1:0]   quot_out_q;
  logic [WIDTH-1:0]   rem_out_q;
  logic [15:0]        pass_cnt_q;
  logic [15:0]        fail_cnt_q;
  logic [15:0]        tmo_cnt_q;

  logic [2*WIDTH:0]   sum_d;
  logic               pass_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // One extra bit on the sum so a product overflow can never alias onto the dividend.
  always_comb begin
    sum_d = {1'b0, prod_q} + {{(WIDTH + 1){1'b0}}, rem_q};
    if (divisor_q == '0) begin
      pass_d = err_q;
    end else begin
      pass_d = !err_q && (rem_q < divisor_q) &&
               (sum_d == {{(WIDTH + 1){1'b0}}, dividend_q});
    end
  end

  // busy_q stays up through the done cycle, so a start is only taken once done has been seen.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      prod_q     <= '0;
      wait_q     <= '0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (done_q) busy_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_in && !busy_q) begin
            dividend_q <= dividend_in;
            divisor_q  <= divisor_in;
            wait_q     <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (result_valid_in) begin
            quot_q  <= quotient_in;
            rem_q   <= remainder_in;
            err_q   <= error_in;
            state_q <= S_MUL;
          end else if (wait_q == WAIT_LAST) begin
            done_q     <= 1'b1;
            pass_q     <= 1'b0;
            fail_cnt_q <= sat_inc(fail_cnt_q);
            tmo_cnt_q  <= sat_inc(tmo_cnt_q);
            state_q    <= S_IDLE;
          end else begin
            wait_q <= wait_q + CW'(1);
          end
        end
        S_MUL: begin
          prod_q  <= (2 * WIDTH)'(quot_q) * (2 * WIDTH)'(divisor_q);
          state_q <= S_CMP;
        end
        S_CMP: begin
          done_q     <= 1'b1;
          pass_q     <= pass_d;
          quot_out_q <= quot_q;
          rem_out_q  <= rem_q;
          if (pass_d) pass_cnt_q <= sat_inc(pass_cnt_q);
          else        fail_cnt_q <= sat_inc(fail_cnt_q);
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign quotient_out      = quot_out_q;
  assign remainder_out     = rem_out_q;
  assign busy_out          = busy_q;
  assign done_out          = done_q;
  assign pass_out          = pass_q;
  assign pass_count_out    = pass_cnt_q;
  assign fail_count_out    = fail_cnt_q;
  assign timeout_count_out = tmo_cnt_q;

endmodule

// File: tb/tb_div_result_checker.sv
// Directed bench for div_result_checker: vector table plus hand-written timing corner cases.
module tb_div_result_checker;
  localparam int W   = 32;
  localparam int TMO = 64;

  logic         clk_in = 1'b0;
  logic         rst_n_in = 1'b0;
  logic         start_in = 1'b0;
  logic [W-1:0] dividend_in = '0;
  logic [W-1:0] divisor_in = '0;
  logic [W-1:0] quotient_in = '0;
  logic [W-1:0] remainder_in = '0;
  logic         result_valid_in = 1'b0;
  logic         error_in = 1'b0;
  logic [W-1:0] quotient_out;
  logic [W-1:0] remainder_out;
  logic         busy_out;
  logic         done_out;
  logic         pass_out;
  logic [15:0]  pass_count_out;
  logic [15:0]  fail_count_out;
  logic [15:0]  timeout_count_out;

  div_result_checker #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .start_in          (start_in),
    .dividend_in       (dividend_in),
    .divisor_in        (divisor_in),
    .quotient_in       (quotient_in),
    .remainder_in      (remainder_in),
    .result_valid_in   (result_valid_in),
    .error_in          (error_in),
    .quotient_out      (quotient_out),
    .remainder_out     (remainder_out),
    .busy_out          (busy_out),
    .done_out          (done_out),
    .pass_out          (pass_out),
    .pass_count_out    (pass_count_out),
    .fail_count_out    (fail_count_out),
    .timeout_count_out (timeout_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dsr;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         e;
    logic         pass;
  } vec_t;

  vec_t vecs[12];

  int           n_cmp = 0;
  int           n_fail = 0;
  logic [15:0]  exp_pc = '0;
  logic [15:0]  exp_fc = '0;
  logic [15:0]  exp_tc = '0;
  logic [W-1:0] exp_q = '0;
  logic [W-1:0] exp_r = '0;
  logic         exp_p = 1'b0;

  function automatic logic [15:0] sinc(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_outputs(input string name);
    chk({name, "_pass"},  64'(pass_out),          64'(exp_p));
    chk({name, "_quot"},  64'(quotient_out),      64'(exp_q));
    chk({name, "_rem"},   64'(remainder_out),     64'(exp_r));
    chk({name, "_pcnt"},  64'(pass_count_out),    64'(exp_pc));
    chk({name, "_fcnt"},  64'(fail_count_out),    64'(exp_fc));
    chk({name, "_tcnt"},  64'(timeout_count_out), 64'(exp_tc));
  endtask

  // Launch, result one cycle later, verdict expected exactly three cycles after the result.
  task automatic run_check(input logic [W-1:0] dvd, input logic [W-1:0] dsr,
                           input logic [W-1:0] q, input logic [W-1:0] r,
                           input logic e, input logic pass, input string name);
    logic early;
    start_in = 1'b1; dividend_in = dvd; divisor_in = dsr;
    tick();
    start_in = 1'b0;
    chk({name, "_busy"}, 64'(busy_out), 64'd1);
    result_valid_in = 1'b1; quotient_in = q; remainder_in = r; error_in = e;
    tick();
    result_valid_in = 1'b0;
    early = done_out;
    tick();
    early = early | done_out;
    tick();
    chk({name, "_done"}, {62'd0, early, done_out}, 64'd1);
    exp_p = pass; exp_q = q; exp_r = r;
    if (pass) exp_pc = sinc(exp_pc);
    else      exp_fc = sinc(exp_fc);
    check_outputs(name);
    tick();
    chk({name, "_idle"}, 64'(busy_out), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int  k;
    logic seen;

    vecs[0]  = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1};
    vecs[1]  = '{32'd100, 32'd7, 32'd14, 32'd9, 1'b0, 1'b0};
    vecs[2]  = '{32'd100, 32'd7, 32'd13, 32'd9, 1'b0, 1'b0};
    vecs[3]  = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0};
    vecs[4]  = '{32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1};
    vecs[5]  = '{32'd5, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0};
    vecs[6]  = '{32'd0, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1};
    vecs[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1};
    vecs[8]  = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b1, 1'b0};
    vecs[9]  = '{32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 1'b1};
    vecs[10] = '{32'd100, 32'd7, 32'd15, 32'd0, 1'b0, 1'b0};
    vecs[11] = '{32'd4, 32'h8000_0000, 32'd2, 32'd4, 1'b0, 1'b0};

    repeat (3) @(posedge clk_in);
    #1;
    check_outputs("reset");
    chk("reset_busy", 64'(busy_out), 64'd0);
    chk("reset_done", 64'(done_out), 64'd0);
    rst_n_in = 1'b1;
    tick();

    for (int i = 0; i < 12; i++)
      run_check(vecs[i].dvd, vecs[i].dsr, vecs[i].q, vecs[i].r, vecs[i].e, vecs[i].pass,
                $sformatf("vec%0d", i));

    // Timeout: no result after launch.
    start_in = 1'b1; dividend_in = 32'd1000; divisor_in = 32'd10;
    tick();
    start_in = 1'b0;
    k = 1;
    while (!done_out && k < 200) begin
      tick();
      k++;
    end
    chk("tmo_latency", 64'(k), 64'(TMO + 1));
    exp_p = 1'b0; exp_fc = sinc(exp_fc); exp_tc = sinc(exp_tc);
    check_outputs("tmo");
    repeat (5) tick();
    chk("tmo_idle", 64'(busy_out), 64'd0);
    result_valid_in = 1'b1; quotient_in = 32'd100; remainder_in = 32'd0; error_in = 1'b0;
    tick();
    result_valid_in = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      seen = seen | done_out | busy_out;
      tick();
    end
    chk("late_rv_ignored", 64'(seen), 64'd0);
    check_outputs("late_rv");

    // Stray result strobe while idle.
    result_valid_in = 1'b1; quotient_in = 32'd14; remainder_in = 32'd2;
    repeat (3) tick();
    result_valid_in = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      seen = seen | done_out;
      tick();
    end
    chk("stray_done", 64'(seen), 64'd0);
    check_outputs("stray");

    // Second start while busy must not replace the captured operands.
    start_in = 1'b1; dividend_in = 32'd100; divisor_in = 32'd7;
    tick();
    dividend_in = 32'd50; divisor_in = 32'd0;
    tick();
    start_in = 1'b0;
    result_valid_in = 1'b1; quotient_in = 32'd14; remainder_in = 32'd2; error_in = 1'b0;
    tick();
    result_valid_in = 1'b0;
    tick();
    tick();
    chk("ovl_done", 64'(done_out), 64'd1);
    exp_p = 1'b1; exp_q = 32'd14; exp_r = 32'd2; exp_pc = sinc(exp_pc);
    check_outputs("ovl");
    tick();

    // Result strobe coincident with the launch belongs to nothing.
    start_in = 1'b1; dividend_in = 32'd100; divisor_in = 32'd7;
    result_valid_in = 1'b1; quotient_in = 32'd14; remainder_in = 32'd2;
    tick();
    start_in = 1'b0;
    remainder_in = 32'd9;
    tick();
    result_valid_in = 1'b0;
    tick();
    tick();
    chk("coin_done", 64'(done_out), 64'd1);
    exp_p = 1'b0; exp_q = 32'd14; exp_r = 32'd9; exp_fc = sinc(exp_fc);
    check_outputs("coin");
    tick();

    // Saturation: preload the pass counter near full scale.
    force dut.pass_cnt_q = 16'hFFFE;
    tick();
    release dut.pass_cnt_q;
    exp_pc = 16'hFFFE;
    run_check(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1, "sat1");
    run_check(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1, "sat2");
    chk("sat_hold", 64'(pass_count_out), 64'hFFFF);

    // Reset while the product is being formed.
    start_in = 1'b1; dividend_in = 32'd100; divisor_in = 32'd7;
    tick();
    start_in = 1'b0;
    result_valid_in = 1'b1; quotient_in = 32'd14; remainder_in = 32'd2; error_in = 1'b0;
    tick();
    result_valid_in = 1'b0;
    rst_n_in = 1'b0;
    #1;
    exp_p = 1'b0; exp_q = '0; exp_r = '0; exp_pc = '0; exp_fc = '0; exp_tc = '0;
    check_outputs("rst_abort");
    chk("rst_abort_busy", 64'(busy_out), 64'd0);
    seen = 1'b0;
    repeat (3) begin
      tick();
      seen = seen | done_out;
    end
    rst_n_in = 1'b1;
    repeat (3) begin
      tick();
      seen = seen | done_out;
    end
    chk("rst_abort_nodone", 64'(seen), 64'd0);
    run_check(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
